// File: rtl/bc_cnt_ctrl.sv
// Bunch-crossing counter controller: wrapping LSB/MSB counter with run control,
// a preload handshake, and a snapshot port that reports the distance since the previous snapshot.
module bc_cnt_ctrl #(
  parameter logic [11:0] LSB_CNT_MAX = 12'd3563
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        clear_i,
  input  logic        tick_i,
  input  logic        load_valid_i,
  input  logic [11:0] load_lsb_i,
  input  logic [2:0]  load_msb_i,
  output logic        load_ready_o,
  input  logic        snap_req_i,
  input  logic        snap_ready_i,
  output logic        snap_valid_o,
  output logic [11:0] snap_lsb_o,
  output logic [2:0]  snap_msb_o,
  output logic [11:0] snap_diff_o,
  output logic [11:0] lsb_cnt_o,
  output logic [2:0]  msb_cnt_o,
  output logic        running_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_e;

  state_e      state_q, state_d;
  logic [11:0] lsb_q, lsb_d;
  logic [2:0]  msb_q, msb_d;
  logic        snap_valid_q, snap_valid_d;
  logic [11:0] snap_lsb_q, snap_lsb_d;
  logic [2:0]  snap_msb_q, snap_msb_d;
  logic [11:0] snap_diff_q, snap_diff_d;
  logic [11:0] prev_lsb_q, prev_lsb_d;
  logic [2:0]  prev_msb_q, prev_msb_d;
  logic        load_fire;
  logic [11:0] diff_same, diff_wrap;

  assign load_ready_o = (state_q == IDLE);
  assign load_fire    = load_valid_i & load_ready_o;

  always_comb begin
    state_d = state_q;
    lsb_d   = lsb_q;
    msb_d   = msb_q;
    if (clear_i) begin
      state_d = IDLE;
      lsb_d   = '0;
      msb_d   = '0;
    end else if (load_fire) begin
      lsb_d = load_lsb_i;
      msb_d = load_msb_i;
      if (load_lsb_i > LSB_CNT_MAX) state_d = ERR;
    end else begin
      case (state_q)
        RUN: begin
          // a stop in the same cycle as a tick still lets that tick count
          if (tick_i) begin
            if (lsb_q == LSB_CNT_MAX) begin
              lsb_d = '0;
              msb_d = msb_q + 3'd1;
            end else begin
              lsb_d = lsb_q + 12'd1;
            end
          end
          if (stop_i) state_d = IDLE;
        end
        IDLE: if (start_i) state_d = RUN;
        default: ;
      endcase
    end
  end

  // a single wrap between snapshots is assumed when the MSB differs
  assign diff_same = lsb_q - prev_lsb_q;
  assign diff_wrap = lsb_q + LSB_CNT_MAX + 12'd1 - prev_lsb_q;

  always_comb begin
    snap_valid_d = snap_valid_q;
    snap_lsb_d   = snap_lsb_q;
    snap_msb_d   = snap_msb_q;
    snap_diff_d  = snap_diff_q;
    prev_lsb_d   = prev_lsb_q;
    prev_msb_d   = prev_msb_q;
    if (clear_i) begin
      snap_valid_d = 1'b0;
      snap_lsb_d   = '0;
      snap_msb_d   = '0;
      snap_diff_d  = '0;
      prev_lsb_d   = '0;
      prev_msb_d   = '0;
    end else if (snap_valid_q) begin
      if (snap_ready_i) snap_valid_d = 1'b0;
    end else if (snap_req_i) begin
      snap_valid_d = 1'b1;
      snap_lsb_d   = lsb_q;
      snap_msb_d   = msb_q;
      snap_diff_d  = (msb_q == prev_msb_q) ? diff_same : diff_wrap;
      prev_lsb_d   = lsb_q;
      prev_msb_d   = msb_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      lsb_q        <= '0;
      msb_q        <= '0;
      snap_valid_q <= 1'b0;
      snap_lsb_q   <= '0;
      snap_msb_q   <= '0;
      snap_diff_q  <= '0;
      prev_lsb_q   <= '0;
      prev_msb_q   <= '0;
    end else begin
      state_q      <= state_d;
      lsb_q        <= lsb_d;
      msb_q        <= msb_d;
      snap_valid_q <= snap_valid_d;
      snap_lsb_q   <= snap_lsb_d;
      snap_msb_q   <= snap_msb_d;
      snap_diff_q  <= snap_diff_d;
      prev_lsb_q   <= prev_lsb_d;
      prev_msb_q   <= prev_msb_d;
    end
  end

  assign lsb_cnt_o    = lsb_q;
  assign msb_cnt_o    = msb_q;
  assign running_o    = (state_q == RUN);
  assign err_o        = (state_q == ERR);
  assign snap_valid_o = snap_valid_q;
  assign snap_lsb_o   = snap_lsb_q;
  assign snap_msb_o   = snap_msb_q;
  assign snap_diff_o  = snap_diff_q;

endmodule

// File: doc/bc_cnt_ctrl.md
BC_CNT_CTRL -- requirements
Module: bc_cnt_ctrl

Interface
REQ-001 SHALL have parameter LSB_CNT_MAX, default 12'd3563: last LSB count value before wrap.
REQ-002 SHALL have port clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports start_i, stop_i, clear_i  in  1 each  run-control pulses.
REQ-005 SHALL have port tick_i  in  1  count-enable strobe.
REQ-006 SHALL have ports load_valid_i  in  1, load_lsb_i  in  12, load_msb_i  in  3, load_ready_o  out  1  preload handshake.
REQ-007 SHALL have ports snap_req_i  in  1, snap_ready_i  in  1, snap_valid_o  out  1  snapshot handshake.
REQ-008 SHALL have ports snap_lsb_o  out  12, snap_msb_o  out  3, snap_diff_o  out  12  snapshot payload.
REQ-009 SHALL have ports lsb_cnt_o  out  12, msb_cnt_o  out  3, running_o  out  1, err_o  out  1  live status.

Function
REQ-010 SHALL implement the FSM states IDLE, RUN and ERR; running_o = (state==RUN); err_o = (state==ERR).
REQ-011 Control priority SHALL be clear_i > load > stop_i > start_i, evaluated every cycle.
REQ-012 clear_i in any state SHALL, next cycle: set state IDLE, counters 0, snap_valid_o 0, previous-snapshot register 0.
REQ-013 IDLE: load_ready_o SHALL be 1; in RUN and ERR it SHALL be 0.
REQ-014 IDLE: load_valid_i & load_ready_o SHALL write load_lsb_i/load_msb_i into the counters next cycle.
REQ-015 A load with load_lsb_i > LSB_CNT_MAX SHALL still write the counters and SHALL move the FSM to ERR.
REQ-016 IDLE + start_i (no load, no clear) SHALL move the FSM to RUN; start_i in RUN or ERR SHALL be ignored.
REQ-017 RUN + tick_i: if lsb==LSB_CNT_MAX then lsb<=0 and msb<=msb+1 (mod 8, 7 wraps to 0); else lsb<=lsb+1, msb unchanged.
REQ-018 RUN + stop_i SHALL move the FSM to IDLE; a tick_i in the same cycle SHALL still be counted.
REQ-019 Counters SHALL hold in IDLE and ERR regardless of tick_i.
REQ-020 ERR SHALL be left only by clear_i or reset.
REQ-021 snap_req_i while snap_valid_o==0 SHALL capture the pre-update registered lsb/msb into snap_lsb_o/snap_msb_o and set snap_valid_o next cycle; allowed in any state.
REQ-022 snap_req_i while snap_valid_o==1 SHALL be ignored; the payload SHALL stay stable while snap_valid_o==1.
REQ-023 snap_valid_o SHALL clear the cycle after snap_valid_o & snap_ready_i; a snap_req_i in that same cycle SHALL be ignored.
REQ-024 snap_diff_o SHALL equal (lsb - prev_lsb) mod 4096 when msb==prev_msb, else (lsb + LSB_CNT_MAX + 1 - prev_lsb) mod 4096.
REQ-025 prev_lsb/prev_msb SHALL be updated to the captured values on each capture; a multi-wrap gap is not detected.
REQ-026 lsb_cnt_o/msb_cnt_o SHALL be the registered counter values, with no combinational path from the inputs.

Reset
REQ-027 While rst_ni==0 the block SHALL asynchronously force: state IDLE, lsb_cnt_o 0, msb_cnt_o 0, snap_valid_o 0, snap_lsb_o 0, snap_msb_o 0, snap_diff_o 0, prev 0, running_o 0, err_o 0, load_ready_o 1.
REQ-028 Reset asserted mid-RUN or mid-snapshot SHALL discard all state; after release the block SHALL need start_i to count.

Verification
REQ-029 Load lsb=3562, msb=7; start_i; 3 ticks -> counts 3563/7, then 0/0, then 1/0; err_o stays 0.
REQ-030 Load lsb=4000 in IDLE -> err_o=1 next cycle; ticks leave counters at 4000; clear_i -> IDLE, counters 0/0.
REQ-031 Same-cycle stop_i+tick_i in RUN at lsb=10 -> lsb=11, running_o=0; further ticks do not count.
REQ-032 Snap at 100/0, then snap at 50/1 with LSB_CNT_MAX=3563 -> second snap_diff_o=3514; with snap_ready_i held low 5 cycles the payload is stable and a new snap_req_i is ignored.
REQ-033 Same-cycle load_valid_i+start_i in IDLE -> load taken, FSM stays IDLE; clear_i concurrent with load -> counters 0.
REQ-034 Assert rst_ni=0 mid-RUN between clock edges -> all outputs reach reset values immediately, without waiting for a clock edge.
